// File: rtl/bus_arbiter_rr.sv
`default_nettype none
// ============================================================================
// Module   : bus_arbiter_rr
// Function : N-master system-bus arbiter, round-robin or fixed priority, with
//            ownership hold, one turnaround cycle and registered one-hot grant.
//            Optional macro ARB_TIMEOUT_EN bounds ownership to MAX_HOLD cycles.
// Revision : 1.0  initial release
// ============================================================================
module bus_arbiter_rr #(
    parameter int NUM_MASTERS = 4,
    parameter int RR_MODE     = 1,
    parameter int SEL_W       = $clog2(NUM_MASTERS),
    parameter int MAX_HOLD    = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_MASTERS-1:0] req,
    output logic [NUM_MASTERS-1:0] grant,
    output logic [SEL_W-1:0]       M_select,
    output logic                   bus_busy
);

    generate
        if (NUM_MASTERS < 2 || NUM_MASTERS > 16) begin : g_bad_num_masters
            $error("bus_arbiter_rr: NUM_MASTERS must be in 2..16");
        end
        if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
            $error("bus_arbiter_rr: MAX_HOLD must be in 2..255");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN  = 2'd1,
        ST_TURN = 2'd2
    } state_t;

    localparam logic [NUM_MASTERS-1:0] c_one        = NUM_MASTERS'(1);
    localparam logic [SEL_W-1:0]       c_last_reset = SEL_W'(NUM_MASTERS - 1);

    state_t                   r_state;
    logic [NUM_MASTERS-1:0]   r_grant;
    logic [SEL_W-1:0]         r_select;
    logic [SEL_W-1:0]         r_last_owner;

    logic [SEL_W-1:0]         w_winner;
    logic [SEL_W-1:0]         w_idx;
    logic                     w_found;
    logic [NUM_MASTERS-1:0]   w_onehot;

    function automatic logic [SEL_W-1:0] f_wrap(input int v);
        return (v >= NUM_MASTERS) ? SEL_W'(v - NUM_MASTERS) : SEL_W'(v);
    endfunction

    // Scan starts just after the last owner in round-robin mode, at 0 otherwise.
    always_comb begin
        w_winner = '0;
        w_idx    = '0;
        w_found  = 1'b0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            w_idx = (RR_MODE != 0) ? f_wrap(int'(r_last_owner) + 1 + k) : SEL_W'(k);
            if (!w_found && req[w_idx]) begin
                w_found  = 1'b1;
                w_winner = w_idx;
            end
        end
    end

    assign w_onehot = c_one << w_winner;

`ifdef ARB_TIMEOUT_EN
    localparam logic [7:0] c_hold_max = 8'(MAX_HOLD - 1);

    logic [7:0] r_hold_cnt;
    logic       w_others;

    assign w_others = |(req & ~r_grant);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_grant      <= '0;
            r_select     <= '0;
            r_last_owner <= c_last_reset;
`ifdef ARB_TIMEOUT_EN
            r_hold_cnt   <= '0;
`endif
        end else begin
            case (r_state)
                // The turnaround cycle arbitrates exactly like idle does.
                ST_IDLE, ST_TURN: begin
                    r_grant <= '0;
                    r_state <= ST_IDLE;
                    if (w_found) begin
                        r_grant      <= w_onehot;
                        r_select     <= w_winner;
                        r_last_owner <= w_winner;
                        r_state      <= ST_OWN;
`ifdef ARB_TIMEOUT_EN
                        r_hold_cnt   <= '0;
`endif
                    end
                end
                ST_OWN: begin
                    if (!req[r_last_owner]) begin
                        r_grant <= '0;
                        r_state <= ST_TURN;
                    end
`ifdef ARB_TIMEOUT_EN
                    else if (r_hold_cnt == c_hold_max) begin
                        // Saturated: yield only if someone else is waiting.
                        if (w_others) begin
                            r_grant <= '0;
                            r_state <= ST_TURN;
                        end
                    end else begin
                        r_hold_cnt <= r_hold_cnt + 8'd1;
                    end
`endif
                end
                default: begin
                    r_grant <= '0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign grant    = r_grant;
    assign M_select = r_select;
    assign bus_busy = |r_grant;

endmodule
`default_nettype wire

// File: tb/tb_bus_arbiter_rr.sv
`default_nettype none
// ============================================================================
// Module   : tb_bus_arbiter_rr
// Function : Directed and random checks of bus_arbiter_rr (round-robin and
//            fixed-priority instances) against an ownership-level model.
// Revision : 1.0  initial release
// ============================================================================
module tb_bus_arbiter_rr;

    localparam int N        = 4;
    localparam int MAX_HOLD = 4;
`ifdef ARB_TIMEOUT_EN
    localparam bit TIMEOUT_EN = 1'b1;
`else
    localparam bit TIMEOUT_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] req = '0;

    logic [N-1:0] grant_rr, grant_fp;
    logic [1:0]   sel_rr, sel_fp;
    logic         busy_rr, busy_fp;

    int n_checks = 0;
    int n_errors = 0;

    // Model state per instance: index 0 = round-robin, 1 = fixed priority.
    int m_owner [2] = '{-1, -1};
    int m_last  [2] = '{N-1, N-1};
    int m_sel   [2] = '{0, 0};
    int m_owned [2] = '{0, 0};

    always #5 clk = ~clk;

    bus_arbiter_rr #(.NUM_MASTERS(N), .RR_MODE(1), .MAX_HOLD(MAX_HOLD)) u_rr (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .grant    (grant_rr),
        .M_select (sel_rr),
        .bus_busy (busy_rr)
    );

    bus_arbiter_rr #(.NUM_MASTERS(N), .RR_MODE(0), .MAX_HOLD(MAX_HOLD)) u_fp (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .grant    (grant_fp),
        .M_select (sel_fp),
        .bus_busy (busy_fp)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input bit rr, input int last, input logic [N-1:0] r);
        for (int k = 1; k <= N; k++) begin
            int i;
            i = rr ? (last + k) % N : k - 1;
            if (r[i[1:0]]) return i;
        end
        return -1;
    endfunction

    task automatic model_step(input int d);
        int o;
        int w;
        if (rst) begin
            m_owner[d] = -1;
            m_last[d]  = N - 1;
            m_sel[d]   = 0;
            m_owned[d] = 0;
            return;
        end
        o = m_owner[d];
        if (o >= 0) begin
            if (!req[o[1:0]])
                m_owner[d] = -1;
            else if (TIMEOUT_EN && m_owned[d] >= MAX_HOLD && (req & ~(4'b0001 << o)) != 0)
                m_owner[d] = -1;
            else
                m_owned[d]++;
        end else begin
            w = pick(d == 0, m_last[d], req);
            if (w >= 0) begin
                m_owner[d] = w;
                m_last[d]  = w;
                m_sel[d]   = w;
                m_owned[d] = 1;
            end
        end
    endtask

    task automatic compare_all();
        logic [N-1:0] g;
        logic [1:0]   s;
        logic         b;
        for (int d = 0; d < 2; d++) begin
            g = (d == 0) ? grant_rr : grant_fp;
            s = (d == 0) ? sel_rr : sel_fp;
            b = (d == 0) ? busy_rr : busy_fp;
            check($sformatf("grant[%0d]", d), 8'(g),
                  (m_owner[d] >= 0) ? 8'(4'b0001 << m_owner[d]) : 8'h00);
            check($sformatf("M_select[%0d]", d), 8'(s), 8'(m_sel[d]));
            check($sformatf("bus_busy[%0d]", d), 8'(b), 8'(m_owner[d] >= 0));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step(0);
        model_step(1);
        @(negedge clk);
        compare_all();
    endtask

    initial begin
        int order[$];
        logic [N-1:0] prev;

        // Reset, then idle
        rst = 1'b1; req = '0;
        tick(); tick();
        check("rst_grant", 8'(grant_rr), 8'h00);
        check("rst_sel", 8'(sel_rr), 8'h00);
        check("rst_busy", 8'(busy_rr), 8'h00);
        rst = 1'b0;
        repeat (5) tick();
        check("idle_grant", 8'(grant_rr), 8'h00);

        // Single request held for 10 cycles
        req = 4'b0100;
        tick();
        check("single_grant", 8'(grant_rr), 8'h04);
        check("single_sel", 8'(sel_rr), 8'h02);
        repeat (9) tick();
        check("single_hold", 8'(grant_rr), 8'h04);
        req = 4'b0000;
        tick();
        check("single_release", 8'(grant_rr), 8'h00);
        check("single_sel_kept", 8'(sel_rr), 8'h02);

        // Round-robin fairness: owners release after 3 cycles and re-request
        rst = 1'b1; tick(); rst = 1'b0;
        prev = '0;
        for (int c = 0; c < 30; c++) begin
            req = 4'hF;
            if (m_owner[0] >= 0 && m_owned[0] >= 3) req[m_owner[0][1:0]] = 1'b0;
            tick();
            if (grant_rr != 0 && prev == 0) order.push_back(int'(sel_rr));
            prev = grant_rr;
        end
        check("rr_order_len", 8'(order.size() >= 5), 8'h01);
        for (int i = 0; i < 5; i++) check($sformatf("rr_order%0d", i), 8'(order[i]), 8'(i % N));

        // Fixed priority: master 1 re-requests and starves master 3
        rst = 1'b1; tick(); rst = 1'b0;
        req = 4'b1010;
        tick();
        check("fp_first", 8'(grant_fp), 8'h02);
        tick(); tick();
        req = 4'b1000;
        tick();
        check("fp_turn", 8'(grant_fp), 8'h00);
        req = 4'b1010;
        tick();
        check("fp_again", 8'(grant_fp), 8'h02);
        tick(); tick();
        check("fp_starve", 8'(grant_fp), 8'h02);

        // Reset in the middle of ownership
        rst = 1'b1; tick(); rst = 1'b0;
        req = 4'b1000;
        tick(); tick();
        check("mid_own", 8'(grant_rr), 8'h08);
        rst = 1'b1;
        tick();
        check("mid_rst_grant", 8'(grant_rr), 8'h00);
        check("mid_rst_sel", 8'(sel_rr), 8'h00);
        rst = 1'b0;
        tick();
        check("mid_regrant", 8'(grant_rr), 8'h08);

`ifdef ARB_TIMEOUT_EN
        // Forced release after MAX_HOLD cycles, then unbounded hold when alone
        rst = 1'b1; tick(); rst = 1'b0;
        req = 4'b0101;
        for (int c = 0; c < 4; c++) begin
            tick();
            check("to_hold", 8'(grant_rr), 8'h01);
        end
        tick();
        check("to_turn", 8'(grant_rr), 8'h00);
        tick();
        check("to_next", 8'(grant_rr), 8'h04);
        check("to_next_sel", 8'(sel_rr), 8'h02);
        rst = 1'b1; tick(); rst = 1'b0;
        req = 4'b0001;
        repeat (22) tick();
        check("to_alone", 8'(grant_rr), 8'h01);
`endif

        // Random traffic with occasional reset
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 3) == 0) req = 4'($urandom);
            rst = ($urandom_range(0, 49) == 0);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
